// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receive-side handshake bundle between UART receiver, FIFO and consumer
//   master : drives ena, rx_data_in, rx_data_in_valid, rx_ready, clear_overflow; observes FIFO status
//   slave  : the FIFO; drives rx_data, rx_valid, count, full, empty, overflow
interface uart_rx_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   logic                         ena;
   logic [DATA_WIDTH-1:0]        rx_data_in;
   logic                         rx_data_in_valid;
   logic [DATA_WIDTH-1:0]        rx_data;
   logic                         rx_valid;
   logic                         rx_ready;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         full;
   logic                         empty;
   logic                         overflow;
   logic                         clear_overflow;
   modport master (
      output ena, rx_data_in, rx_data_in_valid, rx_ready, clear_overflow,
      input  rx_data, rx_valid, count, full, empty, overflow
   );
   modport slave (
      input  ena, rx_data_in, rx_data_in_valid, rx_ready, clear_overflow,
      output rx_data, rx_valid, count, full, empty, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead circular buffer between UART receiver and consumer with sticky overflow
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset of pointers, count and overflow
//   bus   : uart_rx_fifo_if.slave (byte strobe in, valid/ready head out, level and flags)
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic              clk,
   input  logic              reset,
   uart_rx_fifo_if.slave     bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_overflow;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_pop   = bus.ena && !w_empty && bus.rx_ready;
   // a full buffer still accepts a byte when the head leaves in the same cycle
   assign w_push  = bus.ena && bus.rx_data_in_valid && (!w_full || w_pop);
   assign w_drop  = bus.ena && bus.rx_data_in_valid && w_full && !w_pop;
   assign bus.rx_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign bus.rx_valid = !w_empty && bus.ena;
   assign bus.count    = r_count;
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.overflow = r_overflow;
   // storage is not reset; stale contents are unreachable once the pointers reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.rx_data_in;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
         r_count <= (w_push && !w_pop) ? r_count + CW'(1) :
                    (w_pop && !w_push) ? r_count - CW'(1) : r_count;
         // a drop in the same cycle as a clear keeps the flag set
         if (bus.ena) r_overflow <= w_drop ? 1'b1 : bus.clear_overflow ? 1'b0 : r_overflow;
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo (DEPTH 16)
module tb_uart_rx_fifo;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [7:0] exp_q [$];
   always #5 clk = ~clk;
   uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();
   uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // monitor: every accepted head byte must match the oldest expected byte
   always @(negedge clk) begin
      if (!reset && bus.rx_valid && bus.rx_ready) begin
         if (exp_q.size() == 0) chk("unexpected_pop", int'(bus.rx_data), -1);
         else chk("pop_data", int'(bus.rx_data), int'(exp_q.pop_front()));
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push_byte(input logic [7:0] b, input bit kept);
      bus.rx_data_in = b;
      bus.rx_data_in_valid = 1'b1;
      if (kept) exp_q.push_back(b);
      tick();
      bus.rx_data_in_valid = 1'b0;
   endtask
   task automatic drain(input int n);
      bus.rx_ready = 1'b1;
      repeat (n) tick();
      bus.rx_ready = 1'b0;
   endtask
   int mcount;
   bit strobe;
   bit rdy;
   int sent;
   int cyc;
   initial begin
      bus.ena = 1'b1;
      bus.rx_data_in = '0;
      bus.rx_data_in_valid = 1'b0;
      bus.rx_ready = 1'b0;
      bus.clear_overflow = 1'b0;
      repeat (2) tick();
      chk("rst_count", int'(bus.count), 0);
      chk("rst_empty", int'(bus.empty), 1);
      reset = 1'b0;
      tick();
      // 1: async reset with 3 bytes stored
      push_byte(8'h01, 1'b1);
      push_byte(8'h02, 1'b1);
      push_byte(8'h03, 1'b1);
      chk("pre_rst_count", int'(bus.count), 3);
      #2 reset = 1'b1;
      #1;
      exp_q.delete();
      chk("arst_count", int'(bus.count), 0);
      chk("arst_empty", int'(bus.empty), 1);
      chk("arst_valid", int'(bus.rx_valid), 0);
      chk("arst_data", int'(bus.rx_data), 0);
      chk("arst_full", int'(bus.full), 0);
      tick();
      reset = 1'b0;
      tick();
      // 2: order and first-byte latency
      push_byte(8'h41, 1'b1);
      chk("lat_valid", int'(bus.rx_valid), 1);
      chk("lat_data", int'(bus.rx_data), 'h41);
      push_byte(8'h42, 1'b1);
      push_byte(8'h43, 1'b1);
      chk("ord_count", int'(bus.count), 3);
      drain(3);
      chk("ord_empty", int'(bus.empty), 1);
      chk("ord_valid", int'(bus.rx_valid), 0);
      // 3: overflow, 0x10 dropped
      for (int i = 0; i < 17; i++) push_byte(8'(i), i < 16);
      chk("ovf_full", int'(bus.full), 1);
      chk("ovf_count", int'(bus.count), 16);
      chk("ovf_flag", int'(bus.overflow), 1);
      bus.clear_overflow = 1'b1;
      tick();
      bus.clear_overflow = 1'b0;
      chk("ovf_clear", int'(bus.overflow), 0);
      bus.clear_overflow = 1'b1;
      push_byte(8'h77, 1'b0);
      bus.clear_overflow = 1'b0;
      chk("ovf_clr_drop", int'(bus.overflow), 1);
      bus.clear_overflow = 1'b1;
      tick();
      bus.clear_overflow = 1'b0;
      chk("ovf_clear2", int'(bus.overflow), 0);
      // 4: full push with simultaneous pop
      bus.rx_ready = 1'b1;
      push_byte(8'hAA, 1'b1);
      bus.rx_ready = 1'b0;
      chk("fpp_count", int'(bus.count), 16);
      chk("fpp_ovf", int'(bus.overflow), 0);
      chk("fpp_head", int'(bus.rx_data), 'h01);
      drain(16);
      chk("fpp_empty", int'(bus.empty), 1);
      // 5: random-ready stream across pointer wrap
      mcount = 0;
      sent = 0;
      cyc = 0;
      while ((sent < 40 || mcount > 0) && cyc < 400) begin
         rdy = 1'($urandom_range(0, 1));
         strobe = (sent < 40) && (mcount < 16);
         bus.rx_ready = rdy;
         bus.rx_data_in = 8'(8'h80 + sent);
         bus.rx_data_in_valid = strobe;
         if (strobe) begin
            exp_q.push_back(8'(8'h80 + sent));
            sent++;
         end
         tick();
         mcount = mcount + int'(strobe) - int'(rdy && mcount > 0);
         chk("wrap_count", int'(bus.count), mcount);
         cyc++;
      end
      bus.rx_data_in_valid = 1'b0;
      bus.rx_ready = 1'b0;
      chk("wrap_done", cyc < 400 ? 1 : 0, 1);
      chk("wrap_empty", int'(bus.empty), 1);
      // 6: enable low freezes the FIFO
      push_byte(8'h11, 1'b1);
      push_byte(8'h22, 1'b1);
      bus.ena = 1'b0;
      bus.rx_ready = 1'b1;
      #1;
      chk("ena_valid", int'(bus.rx_valid), 0);
      push_byte(8'h55, 1'b0);
      tick();
      chk("ena_count", int'(bus.count), 2);
      chk("ena_ovf", int'(bus.overflow), 0);
      bus.rx_ready = 1'b0;
      bus.ena = 1'b1;
      drain(2);
      chk("ena_empty", int'(bus.empty), 1);
      tick();
      chk("sb_left", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
